gpu_cmd_arbiter: RTL

Shares the GPU's single APB command slave between two command requesters, e.g. host driver and sprite/overlay engine. Each requester streams 32-bit command words over valid/ready. The arbiter grants one requester at a time in round-robin order and locks the grant for a whole command packet: words up to and including the packet-end opcode. It converts each accepted word into a two-phase APB write and holds off while the drawing engine reports busy.

---
 rtl/gpu_cmd_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/gpu_cmd_arbiter.sv
// Round-robin arbiter that shares one APB command slave between two valid/ready
// command streams, locking the grant for a whole packet (up to the end opcode).
module gpu_cmd_arbiter #(
  parameter logic [31:0] CMD_ADDR     = 32'h0000_0000,
  parameter logic [3:0]  PKT_END_OP   = 4'h4,
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        gpu_busy,
  output logic [31:0] pAddr_o,
  output logic [31:0] pDataWrite_o,
  output logic        pSel_o,
  output logic        pEnable_o,
  output logic        pWrite_o,
  output logic [1:0]  grant_o,
  output logic        abort_o
);

  // state  | meaning
  // IDLE   | no owner, arbitrate between valid requesters
  // SETUP  | APB setup phase for the latched word
  // ACCESS | APB access phase; packet ends here on the end opcode
  // HOLD   | owner keeps grant, waiting for its next word or the timeout
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [15:0] TO_LOAD = 16'(HOLD_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        owner;
  logic        last_owner;
  logic [31:0] word_q;
  logic [31:0] addr_q;
  logic [15:0] cnt;
  logic        cand;
  logic        cand_vld;
  logic        owner_vld;
  logic        accept;
  logic        accept_idx;
  logic        timeout;
  logic        pkt_end;

  assign cand_vld  = req0_valid | req1_valid;
  // On a tie the requester that did not own the previous packet wins.
  assign cand      = req0_valid ? (req1_valid & ~last_owner) : 1'b1;
  assign owner_vld = owner ? req1_valid : req0_valid;
  assign pkt_end   = (word_q[31:28] == PKT_END_OP);

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    accept_idx = owner;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (cand_vld && !gpu_busy && !rst) begin
          accept     = 1'b1;
          accept_idx = cand;
          state_nxt  = SETUP;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: state_nxt = pkt_end ? IDLE : HOLD;
      HOLD: begin
        if (owner_vld && !gpu_busy && !rst) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end else if (cnt == 16'd0) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready   = accept & ~accept_idx;
  assign req1_ready   = accept & accept_idx;
  assign pSel_o       = (state == SETUP) || (state == ACCESS);
  assign pEnable_o    = (state == ACCESS);
  assign pWrite_o     = pSel_o;
  assign pAddr_o      = addr_q;
  assign pDataWrite_o = word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      word_q     <= 32'd0;
      addr_q     <= 32'd0;
      cnt        <= 16'd0;
      grant_o    <= 2'b00;
      abort_o    <= 1'b0;
    end else begin
      state   <= state_nxt;
      abort_o <= timeout;
      if (accept) begin
        word_q  <= accept_idx ? req1_data : req0_data;
        addr_q  <= CMD_ADDR;
        owner   <= accept_idx;
        grant_o <= accept_idx ? 2'b10 : 2'b01;
      end
      if (state == ACCESS) begin
        if (pkt_end) begin
          last_owner <= owner;
          grant_o    <= 2'b00;
        end else begin
          cnt <= TO_LOAD;
        end
      end
      if (state == HOLD && !accept) begin
        if (timeout) begin
          last_owner <= owner;
          grant_o    <= 2'b00;
        end else begin
          cnt <= cnt - 16'd1;
        end
      end
    end
  end

endmodule
